// File: rtl/relational_operators_pkg.sv
// Shared types and constants for the relational_operators comparator.
//   DEFAULT_WIDTH  : default operand width
//   relop_flags_t  : primary relation flags {greater, lease, equal}; the
//                    complement outputs are derived from these
//   RELOP_RESET    : flag value for comparing 0 with 0, used as reset state
package relational_operators_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef struct packed {
        logic greater;
        logic lease;
        logic equal;
    } relop_flags_t;

    localparam relop_flags_t RELOP_RESET = '{greater: 1'b0, lease: 1'b0, equal: 1'b1};

endpackage

// File: rtl/relop_core.sv
// Combinational magnitude/equality compare of two WIDTH-bit operands.
//   a, b    : operands
//   flags_o : {greater, lease, equal}, exactly one bit set
// Build option RELATIONAL_OPERATORS_SIGNED_EN selects two's-complement
// ordering; without it the operands are compared as unsigned.
module relop_core
    import relational_operators_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output relop_flags_t     flags_o
);

    logic gt;
    logic lt;

`ifdef RELATIONAL_OPERATORS_SIGNED_EN
    assign gt = $signed(a) > $signed(b);
    assign lt = $signed(a) < $signed(b);
`else
    assign gt = a > b;
    assign lt = a < b;
`endif

    // Equality does not depend on signedness.
    always_comb begin
        flags_o.greater = gt;
        flags_o.lease   = lt;
        flags_o.equal   = (a == b);
    end

endmodule

// File: rtl/relational_operators.sv
// Registered comparator producing all six relational flags.
//   clk, reset : clock, synchronous active-high reset
//   a, b       : WIDTH-bit operands, sampled when in_valid=1
//   in_valid   : operand qualifier
//   greater/lease/no_lease/no_great/equal/no_equal : registered relations
//   out_valid  : flags correspond to the pair sampled on the previous edge
// Build option RELATIONAL_OPERATORS_SIGNED_EN: signed operand ordering.
module relational_operators
    import relational_operators_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             greater,
    output logic             lease,
    output logic             no_lease,
    output logic             no_great,
    output logic             equal,
    output logic             no_equal,
    output logic             out_valid
);

    relop_flags_t flags_d;
    relop_flags_t flags_q;
    logic         valid_q;

    relop_core #(.WIDTH(WIDTH)) u_core (
        .a       (a),
        .b       (b),
        .flags_o (flags_d)
    );

    // Flags hold while in_valid=0; only out_valid tracks every edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= RELOP_RESET;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) flags_q <= flags_d;
        end
    end

    // Complements come from the same register, so they can never disagree.
    assign greater   = flags_q.greater;
    assign lease     = flags_q.lease;
    assign equal     = flags_q.equal;
    assign no_lease  = ~flags_q.lease;
    assign no_great  = ~flags_q.greater;
    assign no_equal  = ~flags_q.equal;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_relational_operators.sv
module tb_relational_operators;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         greater, lease, no_lease, no_great, equal, no_equal, out_valid;

    int n_chk  = 0;
    int n_fail = 0;

    // Observed vector: {out_valid, greater, lease, no_lease, no_great, equal, no_equal}
    logic [6:0] exp_q[$];
    logic [2:0] mdl;   // model of held {greater, lease, equal}

    relational_operators #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid),
        .greater(greater), .lease(lease), .no_lease(no_lease),
        .no_great(no_great), .equal(equal), .no_equal(no_equal),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] pack_exp(input logic [2:0] f, input logic v);
        return {v, f[2], f[1], ~f[1], ~f[2], f[0], ~f[0]};
    endfunction

    function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y);
        int ix, iy;
`ifdef RELATIONAL_OPERATORS_SIGNED_EN
        ix = int'($signed(x));
        iy = int'($signed(y));
`else
        ix = int'({28'd0, x});
        iy = int'({28'd0, y});
`endif
        return {ix > iy, ix < iy, ix == iy};
    endfunction

    // Drive one cycle, push the expectation, then pop and compare after the edge.
    task automatic step(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic v, input logic r);
        logic [6:0] obs;
        logic       inv;
        a = x; b = y; in_valid = v; reset = r;
        if (r) begin
            mdl = 3'b001;
            exp_q.push_back(pack_exp(mdl, 1'b0));
        end else if (v) begin
            mdl = ref_cmp(x, y);
            exp_q.push_back(pack_exp(mdl, 1'b1));
        end else begin
            exp_q.push_back(pack_exp(mdl, 1'b0));
        end
        @(posedge clk);
        #1;
        obs = {out_valid, greater, lease, no_lease, no_great, equal, no_equal};
        if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else chk(tag, {25'd0, obs}, {25'd0, exp_q.pop_front()});
        inv = (no_lease === ~lease) && (no_great === ~greater) && (no_equal === ~equal)
              && (!out_valid || ({1'b0, greater} + {1'b0, lease} + {1'b0, equal} == 2'd1));
        chk({tag, "_inv"}, {31'd0, inv}, 32'd1);
    endtask

    initial begin
        logic [7:0] cnt;
        mdl = 3'b001;
        a = '0; b = '0; in_valid = 1'b0; reset = 1'b1;
        step("reset", 4'h5, 4'h3, 1'b1, 1'b1);
        step("reset", 4'h5, 4'h3, 1'b1, 1'b1);
        step("gt",    4'h9, 4'h2, 1'b1, 1'b0);
        step("eq",    4'h7, 4'h7, 1'b1, 1'b0);
        step("lt",    4'h0, 4'hF, 1'b1, 1'b0);
        step("hold",  4'h3, 4'hC, 1'b0, 1'b0);
        step("hold",  4'hE, 4'h1, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            cnt = i[7:0];
            step("sweep", cnt[7:4], cnt[3:0], 1'b1, 1'b0);
        end
        step("sign",  4'h8, 4'h7, 1'b1, 1'b0);
        step("sign",  4'h7, 4'h8, 1'b1, 1'b0);
        step("rst_discard", 4'hA, 4'h1, 1'b1, 1'b1);
        step("after_rst",   4'h1, 4'hA, 1'b1, 1'b0);
        step("hold_end",    4'h1, 4'h1, 1'b0, 1'b0);
        if (exp_q.size() != 0) chk("sb_leftover", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
